// File: rtl/usrt_tx.sv
// rtl/usrt_tx.sv - USRT transmit stage: one-entry holding register, shifter and serial clock generator
module usrt_tx #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Tx_En,
    input  logic [31:0] i_Pwdata,
    input  logic        i_Ovr_Clr,
    output logic        o_Usrt_Clk,
    output logic        o_Usrt_Data,
    output logic        o_Tx_Busy,
    output logic        o_Tx_Empty,
    output logic        o_Tx_Done,
    output logic        o_Overrun
);

    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] shifter;
    logic [DIV_W-1:0]  div;
    logic [CNT_W-1:0]  bit_cnt;
    logic              bit_end;
    logic              xfer;
    logic              accept;

    generate
        if (DATA_W < 32) begin : g_pwdata_high
            logic unused_pwdata_high;
            assign unused_pwdata_high = ^i_Pwdata[31:DATA_W];
        end
    endgenerate

    assign bit_end = (state != IDLE) && (div == DIV_LAST);
    // Holding register drains either from idle or at the end of a stop bit, so frames run back to back.
    assign xfer    = !o_Tx_Empty && ((state == IDLE) || ((state == STOP) && bit_end));
    assign accept  = i_Tx_En && (o_Tx_Empty || xfer);

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            state       <= IDLE;
            hold        <= '0;
            shifter     <= '0;
            div         <= '0;
            bit_cnt     <= '0;
            o_Usrt_Clk  <= 1'b0;
            o_Usrt_Data <= 1'b1;
            o_Tx_Busy   <= 1'b0;
            o_Tx_Empty  <= 1'b1;
            o_Tx_Done   <= 1'b0;
            o_Overrun   <= 1'b0;
        end else begin
            o_Tx_Done <= 1'b0;

            if (accept) begin
                hold       <= i_Pwdata[DATA_W-1:0];
                o_Tx_Empty <= 1'b0;
            end else if (xfer) begin
                o_Tx_Empty <= 1'b1;
            end

            if (i_Tx_En && !accept) begin
                o_Overrun <= 1'b1;
            end else if (i_Ovr_Clr) begin
                o_Overrun <= 1'b0;
            end

            if (xfer) begin
                state       <= START;
                shifter     <= hold;
                bit_cnt     <= '0;
                div         <= '0;
                o_Tx_Busy   <= 1'b1;
                o_Usrt_Clk  <= 1'b0;
                o_Usrt_Data <= 1'b0;
            end else if (state != IDLE) begin
                if (!bit_end) begin
                    div <= div + 1'b1;
                    if (div == DIV_HALF) begin
                        o_Usrt_Clk <= 1'b1;
                    end
                end else begin
                    // Bit boundary: serial clock drops and the next bit is driven.
                    div        <= '0;
                    o_Usrt_Clk <= 1'b0;
                    case (state)
                        START: begin
                            state       <= DATA;
                            o_Usrt_Data <= shifter[0];
                        end
                        DATA: begin
                            shifter <= shifter >> 1;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == CNT_LAST) begin
                                state       <= STOP;
                                o_Usrt_Data <= 1'b1;
                            end else begin
                                o_Usrt_Data <= shifter[1];
                            end
                        end
                        default: begin
                            state       <= IDLE;
                            o_Tx_Busy   <= 1'b0;
                            o_Usrt_Data <= 1'b1;
                            o_Tx_Done   <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/usrt_tx.md
Name: usrt_tx

Overview:
Transmit stage of the USRT, directly downstream of the APB bus interface decoder. Captures APB write data when the decoder's transmit-register enable fires and holds it in a one-entry holding register. Moves each byte into a shift register and serialises it onto a synchronous line, with a generated serial clock. Reports busy, empty, done and overrun status for the status register.

Parameters:
DATA_W, 8, data bits per frame; taken from i_Pwdata[DATA_W-1:0]
CLK_DIV, 4, system clocks per half serial-clock period; must be >= 2; one bit time = 2*CLK_DIV clocks

Ports:
i_Clock  in  1  system clock; all state changes on rising edge
i_Reset  in  1  asynchronous, active-low reset
i_Tx_En  in  1  transmit-register write strobe from the bus interface; one cycle per APB access phase
i_Pwdata  in  32  APB write data; bits [DATA_W-1:0] used
i_Ovr_Clr  in  1  single-cycle clear of o_Overrun, from the status-register write path
o_Usrt_Clk  out  1  serial clock; low when idle
o_Usrt_Data  out  1  serial data; high when idle
o_Tx_Busy  out  1  high while a frame is on the line
o_Tx_Empty  out  1  holding register empty; can accept a write
o_Tx_Done  out  1  one-cycle pulse when the line returns to idle
o_Overrun  out  1  sticky; set when a write is lost

Behaviour:
- Reset (i_Reset=0, any time, asynchronous):
  - State IDLE; holding register and shifter cleared; divider and bit counter = 0.
  - Outputs: o_Usrt_Clk=0, o_Usrt_Data=1, o_Tx_Busy=0, o_Tx_Empty=1, o_Tx_Done=0, o_Overrun=0.
  - Reset mid-frame abandons the frame immediately; no done pulse.
- Frame format: start bit (0), DATA_W data bits LSB first, stop bit (1). Length = DATA_W+2 bits.
- Write accept: on an edge with i_Tx_En=1:
  - If o_Tx_Empty=1, or a transfer out of the holding register happens on the same edge, then holding <= i_Pwdata[DATA_W-1:0] and o_Tx_Empty <= 0.
  - Otherwise the data is discarded and o_Overrun <= 1.
- Set/clear priority: overrun set wins over i_Ovr_Clr on the same edge.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on the first edge where the holding register is full. On that edge: shifter <= holding, o_Tx_Empty <= 1, o_Tx_Busy <= 1, o_Usrt_Data <= 0, divider <= 0.
  - Write-to-line latency from idle: the write is captured at edge N, START begins at edge N+1.
  - Each bit lasts exactly 2*CLK_DIV clocks. o_Usrt_Clk is 0 for the first CLK_DIV clocks and 1 for the second CLK_DIV clocks.
  - o_Usrt_Data changes only on the clk-low transition (bit boundary). Receivers sample on the o_Usrt_Clk rising edge.
  - START -> DATA after one bit time. DATA shifts right once per bit and counts DATA_W bits, then -> STOP.
  - STOP end, holding full: transfer and go straight to START on the same edge. Back-to-back frames have no idle gap; o_Tx_Done is not pulsed.
  - STOP end, holding empty: -> IDLE, o_Tx_Busy <= 0, o_Usrt_Clk=0, o_Usrt_Data=1, o_Tx_Done=1 for exactly one cycle.
- Frame duration: (DATA_W+2)*2*CLK_DIV clocks; 80 clocks at the defaults.
- Output timing: all outputs are registered; none are combinational from inputs.
- Width rule: i_Pwdata bits above DATA_W-1 are ignored.

Test Plan:
- Reset -> Usrt_Clk=0, Data=1, Busy=0, Empty=1, Done=0, Overrun=0. Assert reset mid-frame at clock 30 -> all outputs return to these reset values immediately, with no Done pulse.
- Write 0xA5 from idle -> Empty falls at edge N, rises at N+1; Busy=1.
  - Data on the 10 rising edges of Usrt_Clk = 0,1,0,1,0,0,1,0,1,1.
  - Usrt_Clk period = 8 clocks.
  - Done pulses once at N+1+80; Busy=0 on the same edge.
- Write 0x3C, then write 0xC3 at clock 20 of that frame -> second write accepted (Empty=0).
  - Second frame's start bit begins on the edge the first stop bit ends.
  - No idle-high gap; exactly one Done, after 160 clocks.
- Write 3 bytes during one frame (holding full) -> third byte lost, Overrun=1; the line carries only bytes 1 and 2. Pulse i_Ovr_Clr -> Overrun=0.
- Assert i_Tx_En and i_Ovr_Clr together while holding is full -> Overrun remains 1.
- Write 0xFFFFFF81 -> line carries data bits of 0x81 only (1,0,0,0,0,0,0,1, LSB first).
